// File: rtl/human_move_ctrl.sv
// Paced, grid-bounded movement controller for the human character.
// Turns keyboard direction levels into one step per tick and hands each step to the drawer via req/ack.
module human_move_ctrl #(
    parameter int GRID_W     = 160,
    parameter int GRID_H     = 120,
    parameter int START_X    = 80,
    parameter int START_Y    = 60,
    parameter int STEP_TICKS = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       freeze,
    input  logic       draw_ack,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic [7:0] old_x,
    output logic [6:0] old_y,
    output logic [7:0] new_x,
    output logic [6:0] new_y,
    output logic       draw_req,
    output logic       blocked
);

    localparam int              CNT_W   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_TICKS - 1);

    typedef enum logic {
        S_WAIT,
        S_REQ
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [7:0]       r_pos_x;
    logic [6:0]       r_pos_y;
    logic [7:0]       r_old_x;
    logic [6:0]       r_old_y;
    logic [7:0]       r_new_x;
    logic [6:0]       r_new_y;
    logic             r_blocked;
    logic [8:0]       w_tx;
    logic [7:0]       w_ty;
    logic             w_move;
    logic             w_in_grid;
    logic             w_launch;
    logic             w_block;
    logic             w_commit;

    assign w_tick = (r_cnt == CNT_MAX);

    // Free-running step pacer; only reset restarts it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Targets carry one extra bit so stepping left/up from 0 lands out of range instead of wrapping.
    always_comb begin
        w_tx   = {1'b0, r_pos_x};
        w_ty   = {1'b0, r_pos_y};
        w_move = 1'b1;
        if (up) begin
            w_ty = {1'b0, r_pos_y} - 8'd1;
        end else if (down) begin
            w_ty = {1'b0, r_pos_y} + 8'd1;
        end else if (left) begin
            w_tx = {1'b0, r_pos_x} - 9'd1;
        end else if (right) begin
            w_tx = {1'b0, r_pos_x} + 9'd1;
        end else begin
            w_move = 1'b0;
        end
    end

    assign w_in_grid = (w_tx < 9'(GRID_W)) && (w_ty < 8'(GRID_H));

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_block  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_tick && !freeze && w_move) begin
                    if (w_in_grid) begin
                        w_launch = 1'b1;
                        w_next   = S_REQ;
                    end else begin
                        w_block = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (draw_ack) begin
                    w_commit = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            default: w_next = S_WAIT;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_pos_x   <= 8'(START_X);
            r_pos_y   <= 7'(START_Y);
            r_old_x   <= 8'(START_X);
            r_old_y   <= 7'(START_Y);
            r_new_x   <= 8'(START_X);
            r_new_y   <= 7'(START_Y);
            r_blocked <= 1'b0;
        end else begin
            r_blocked <= w_block;
            if (w_launch) begin
                r_old_x <= r_pos_x;
                r_old_y <= r_pos_y;
                r_new_x <= w_tx[7:0];
                r_new_y <= w_ty[6:0];
            end
            if (w_commit) begin
                r_pos_x <= r_new_x;
                r_pos_y <= r_new_y;
            end
        end
    end

    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign old_x    = r_old_x;
    assign old_y    = r_old_y;
    assign new_x    = r_new_x;
    assign new_y    = r_new_y;
    assign draw_req = (r_state == S_REQ);
    assign blocked  = r_blocked;

endmodule

// File: tb/tb_human_move_ctrl.sv
// Directed bench for human_move_ctrl: a mid-grid instance for stepping/handshake
// behaviour and a corner instance (159,0) for out-of-grid blocking.
module tb_human_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       up, down, left, right, freeze, draw_ack;
    logic [7:0] pos_x, old_x, new_x;
    logic [6:0] pos_y, old_y, new_y;
    logic       draw_req, blocked;

    logic       e_up, e_right;
    logic [7:0] e_pos_x, e_old_x, e_new_x;
    logic [6:0] e_pos_y, e_old_y, e_new_y;
    logic       e_req, e_blocked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    human_move_ctrl #(
        .GRID_W(160), .GRID_H(120), .START_X(80), .START_Y(60), .STEP_TICKS(4)
    ) dut (
        .CLOCK_50(clk), .reset(reset),
        .up(up), .down(down), .left(left), .right(right),
        .freeze(freeze), .draw_ack(draw_ack),
        .pos_x(pos_x), .pos_y(pos_y),
        .old_x(old_x), .old_y(old_y),
        .new_x(new_x), .new_y(new_y),
        .draw_req(draw_req), .blocked(blocked)
    );

    human_move_ctrl #(
        .GRID_W(160), .GRID_H(120), .START_X(159), .START_Y(0), .STEP_TICKS(4)
    ) dut_edge (
        .CLOCK_50(clk), .reset(reset),
        .up(e_up), .down(1'b0), .left(1'b0), .right(e_right),
        .freeze(1'b0), .draw_ack(1'b1),
        .pos_x(e_pos_x), .pos_y(e_pos_y),
        .old_x(e_old_x), .old_y(e_old_y),
        .new_x(e_new_x), .new_y(e_new_y),
        .draw_req(e_req), .blocked(e_blocked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        freeze = 1'b0; draw_ack = 1'b0; e_up = 1'b0; e_right = 1'b0;
        adv(3);
        // Release reset; edge numbers below count posedges after release.
        reset = 1'b0; right = 1'b1; draw_ack = 1'b1; e_up = 1'b1;
        chk("rst_pos_x", pos_x, 80);
        chk("rst_pos_y", pos_y, 60);
        chk("rst_req", draw_req, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_old_x", old_x, 80);
        chk("rst_new_y", new_y, 60);

        adv(3); // edge 3
        chk("pre_tick_req", draw_req, 0);
        chk("edge_pre_blocked", e_blocked, 0);

        adv(1); // edge 4: first tick
        chk("r1_req", draw_req, 1);
        chk("r1_old_x", old_x, 80);
        chk("r1_old_y", old_y, 60);
        chk("r1_new_x", new_x, 81);
        chk("r1_new_y", new_y, 60);
        chk("r1_blocked", blocked, 0);
        chk("edge_up_blocked", e_blocked, 1);
        chk("edge_up_req", e_req, 0);
        chk("edge_up_pos_y", e_pos_y, 0);

        adv(1); // edge 5
        chk("r1_commit_req", draw_req, 0);
        chk("r1_commit_pos_x", pos_x, 81);
        chk("edge_up_blocked_end", e_blocked, 0);

        adv(3); // edge 8
        chk("r2_req", draw_req, 1);
        chk("r2_old_x", old_x, 81);
        chk("r2_new_x", new_x, 82);
        chk("edge_up_blocked2", e_blocked, 1);

        adv(1); // edge 9
        chk("r2_commit_req", draw_req, 0);
        chk("r2_commit_pos_x", pos_x, 82);
        right = 1'b0; up = 1'b1; draw_ack = 1'b0; e_up = 1'b0; e_right = 1'b1;

        adv(3); // edge 12
        chk("u_req", draw_req, 1);
        chk("u_old_y", old_y, 60);
        chk("u_new_x", new_x, 82);
        chk("u_new_y", new_y, 59);
        chk("edge_right_blocked", e_blocked, 1);
        chk("edge_right_pos_x", e_pos_x, 159);
        chk("edge_right_req", e_req, 0);

        adv(1); // edge 13
        chk("edge_right_blocked_end", e_blocked, 0);

        adv(3); // edge 16: dropped tick
        chk("u_hold_req", draw_req, 1);
        chk("u_hold_new_y", new_y, 59);
        chk("u_hold_old_y", old_y, 60);
        chk("u_hold_pos_y", pos_y, 60);

        adv(5); // edge 21
        chk("u_hold2_req", draw_req, 1);
        chk("u_hold2_new_y", new_y, 59);
        draw_ack = 1'b1;

        adv(1); // edge 22
        chk("u_commit_req", draw_req, 0);
        chk("u_commit_pos_y", pos_y, 59);
        chk("u_commit_pos_x", pos_x, 82);
        up = 1'b0; draw_ack = 1'b0;

        adv(2); // edge 24
        chk("u_once_req", draw_req, 0);
        chk("u_once_pos_y", pos_y, 59);
        up = 1'b1; left = 1'b1; draw_ack = 1'b1;

        adv(4); // edge 28
        chk("prio_req", draw_req, 1);
        chk("prio_new_x", new_x, 82);
        chk("prio_new_y", new_y, 58);

        adv(1); // edge 29
        chk("prio_pos_x", pos_x, 82);
        chk("prio_pos_y", pos_y, 58);
        up = 1'b0; left = 1'b0; right = 1'b1; freeze = 1'b1;

        for (int i = 0; i < 5; i++) begin // edges 32..48
            adv(i == 0 ? 3 : 4);
            chk("freeze_req", draw_req, 0);
        end
        chk("freeze_pos_x", pos_x, 82);
        freeze = 1'b0; draw_ack = 1'b0;

        adv(4); // edge 52
        chk("fz_req", draw_req, 1);
        chk("fz_old_x", old_x, 82);
        chk("fz_new_x", new_x, 83);
        freeze = 1'b1;

        adv(2); // edge 54
        chk("fz_hold_req", draw_req, 1);
        chk("fz_hold_pos_x", pos_x, 82);
        draw_ack = 1'b1;

        adv(1); // edge 55
        chk("fz_commit_req", draw_req, 0);
        chk("fz_commit_pos_x", pos_x, 83);
        freeze = 1'b0; right = 1'b0; draw_ack = 1'b0; down = 1'b1;

        adv(1); // edge 56
        chk("d_req", draw_req, 1);
        chk("d_new_y", new_y, 59);
        reset = 1'b1;

        adv(1); // edge 57: reset abandons the step
        chk("abort_req", draw_req, 0);
        chk("abort_pos_x", pos_x, 80);
        chk("abort_pos_y", pos_y, 60);
        reset = 1'b0; down = 1'b0; draw_ack = 1'b1;

        adv(3);
        chk("stray_ack_req", draw_req, 0);
        chk("stray_ack_pos_x", pos_x, 80);
        chk("stray_ack_pos_y", pos_y, 60);
        chk("stray_ack_old_x", old_x, 80);
        chk("stray_ack_new_y", new_y, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
